// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: data-memory access types,
// mcause codes and the trap handshake FSM encoding.
package ex_mem_stage_pkg;

  localparam int XLEN    = 32;
  localparam int CAUSE_W = 5;

  typedef enum logic [2:0] {
    dm_word           = 3'b000,
    dm_half           = 3'b001,
    dm_half_unsigned  = 3'b010,
    dm_byte           = 3'b011,
    dm_byte_unsigned  = 3'b100
  } dm_type_e;

  localparam logic [4:0] EXC_ILLEGAL     = 5'd2;
  localparam logic [4:0] EXC_LD_MISALIGN = 5'd4;
  localparam logic [4:0] EXC_ST_MISALIGN = 5'd6;
  localparam logic [4:0] EXC_ECALL       = 5'd11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP     = 2'd1,
    WAIT_ACK = 2'd2
  } trap_state_e;

endpackage

// File: rtl/ex_mem_stage_exc_detect.sv
// Combinational EX-stage exception detector: illegal > ecall > misaligned access.
// A zero instruction word is a bubble and never raises an exception.
module exc_detect
  import ex_mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) (
  input  logic [31:0]       inst_i,
  input  logic              illegal_i,
  input  logic              ecall_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        dm_type_i,
  input  logic [XLEN-1:0]   addr_i,
  output logic              exc_hit_o,
  output logic [CAUSE_W-1:0] cause_o,
  output logic [XLEN-1:0]   tval_o
);

  logic inst_valid;
  logic misaligned;

  always_comb begin
    inst_valid = (inst_i != 32'd0);
    misaligned = 1'b0;
    // Byte accesses and unused type codes can never be misaligned
    case (dm_type_i)
      dm_word:                   misaligned = (addr_i[1:0] != 2'b00);
      dm_half, dm_half_unsigned: misaligned = addr_i[0];
      default:                   misaligned = 1'b0;
    endcase
    misaligned = misaligned & (mem_read_i | mem_write_i);

    exc_hit_o = 1'b0;
    cause_o   = '0;
    tval_o    = '0;
    if (inst_valid) begin
      if (illegal_i) begin
        exc_hit_o = 1'b1;
        cause_o   = CAUSE_W'(EXC_ILLEGAL);
        tval_o    = XLEN'(inst_i);
      end else if (ecall_i) begin
        exc_hit_o = 1'b1;
        cause_o   = CAUSE_W'(EXC_ECALL);
      end else if (misaligned) begin
        exc_hit_o = 1'b1;
        cause_o   = mem_read_i ? CAUSE_W'(EXC_LD_MISALIGN) : CAUSE_W'(EXC_ST_MISALIGN);
        tval_o    = addr_i;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with exception capture and a trap handshake FSM
// (IDLE -> TRAP -> WAIT_ACK -> IDLE) that flushes younger stages.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [XLEN-1:0]    PC_in,
  input  logic [31:0]        inst_in,
  input  logic [4:0]         rd_in,
  input  logic [XLEN-1:0]    alu_in,
  input  logic [XLEN-1:0]    rs2_data_in,
  input  logic               MemRead_in,
  input  logic               MemWrite_in,
  input  logic               RegWrite_in,
  input  logic [2:0]         DMType_in,
  input  logic [1:0]         WDSel_in,
  input  logic               load_in,
  input  logic               illegal_in,
  input  logic               ecall_in,
  input  logic               trap_ack,
  output logic [XLEN-1:0]    PC_out,
  output logic [31:0]        inst_out,
  output logic [4:0]         rd_out,
  output logic [XLEN-1:0]    alu_out,
  output logic [XLEN-1:0]    rs2_data_out,
  output logic               MemRead_out,
  output logic               MemWrite_out,
  output logic               RegWrite_out,
  output logic [2:0]         DMType_out,
  output logic [1:0]         WDSel_out,
  output logic               load_out,
  output logic               flush_req,
  output logic               exc_valid,
  output logic [CAUSE_W-1:0] exc_cause,
  output logic [XLEN-1:0]    exc_pc,
  output logic [XLEN-1:0]    exc_tval
);

  trap_state_e        state_q;
  logic [XLEN-1:0]    pc_q, alu_q, rs2_q, exc_pc_q, exc_tval_q;
  logic [31:0]        inst_q;
  logic [4:0]         rd_q;
  logic               mem_read_q, mem_write_q, reg_write_q, load_q;
  logic [2:0]         dm_type_q;
  logic [1:0]         wd_sel_q;
  logic               flush_req_q, exc_valid_q;
  logic [CAUSE_W-1:0] exc_cause_q;

  logic               exc_hit;
  logic [CAUSE_W-1:0] exc_cause_d;
  logic [XLEN-1:0]    exc_tval_d;
  logic               trap_busy, load_en, kill, take_exc, kill_ctrl;

  exc_detect #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) u_exc_detect (
    .inst_i      (inst_in),
    .illegal_i   (illegal_in),
    .ecall_i     (ecall_in),
    .mem_read_i  (MemRead_in),
    .mem_write_i (MemWrite_in),
    .dm_type_i   (DMType_in),
    .addr_i      (alu_in),
    .exc_hit_o   (exc_hit),
    .cause_o     (exc_cause_d),
    .tval_o      (exc_tval_d)
  );

  // A pending trap outranks flush and stall: the stage keeps loading bubbles.
  assign trap_busy = (state_q != IDLE);
  assign kill      = trap_busy | flush;
  assign load_en   = kill | ~stall;
  assign take_exc  = ~kill & ~stall & exc_hit;
  assign kill_ctrl = kill | take_exc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      inst_q      <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      rs2_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      dm_type_q   <= '0;
      wd_sel_q    <= '0;
      load_q      <= 1'b0;
      flush_req_q <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_pc_q    <= '0;
      exc_tval_q  <= '0;
    end else begin
      if (load_en) begin
        pc_q        <= kill ? '0 : PC_in;
        inst_q      <= kill ? '0 : inst_in;
        rd_q        <= rd_in;
        alu_q       <= alu_in;
        rs2_q       <= rs2_data_in;
        dm_type_q   <= DMType_in;
        wd_sel_q    <= WDSel_in;
        mem_read_q  <= kill_ctrl ? 1'b0 : MemRead_in;
        mem_write_q <= kill_ctrl ? 1'b0 : MemWrite_in;
        reg_write_q <= kill_ctrl ? 1'b0 : RegWrite_in;
        load_q      <= kill_ctrl ? 1'b0 : load_in;
      end

      case (state_q)
        IDLE: begin
          if (take_exc) begin
            state_q     <= TRAP;
            flush_req_q <= 1'b1;
            exc_valid_q <= 1'b1;
            exc_cause_q <= exc_cause_d;
            exc_pc_q    <= PC_in;
            exc_tval_q  <= exc_tval_d;
          end
        end
        TRAP: begin
          state_q     <= WAIT_ACK;
          flush_req_q <= 1'b0;
        end
        WAIT_ACK: begin
          if (trap_ack) begin
            state_q     <= IDLE;
            exc_valid_q <= 1'b0;
            exc_cause_q <= '0;
            exc_pc_q    <= '0;
            exc_tval_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PC_out       = pc_q;
  assign inst_out     = inst_q;
  assign rd_out       = rd_q;
  assign alu_out      = alu_q;
  assign rs2_data_out = rs2_q;
  assign MemRead_out  = mem_read_q;
  assign MemWrite_out = mem_write_q;
  assign RegWrite_out = reg_write_q;
  assign DMType_out   = dm_type_q;
  assign WDSel_out    = wd_sel_q;
  assign load_out     = load_q;
  assign flush_req    = flush_req_q;
  assign exc_valid    = exc_valid_q;
  assign exc_cause    = exc_cause_q;
  assign exc_pc       = exc_pc_q;
  assign exc_tval     = exc_tval_q;

endmodule
